// File: rtl/vector_scalar_pack_unit.sv
// Gathers lane-0 scalars of pack-mode chains into dense N-lane vectors; passthrough chains go straight out.
// Optional macro VSPU_FLUSH_TIMEOUT_EN adds an idle-timeout flush of a partial buffer.
module vector_scalar_pack_unit #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int TIMEOUT            = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic                            eof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]   chainId_in,
  input  logic                            tracing,
  input  logic [7:0]                      configId,
  input  logic [7:0]                      configData,
  input  logic [N*DATA_WIDTH-1:0]         vector_in,
  output logic                            valid_out,
  output logic [N*DATA_WIDTH-1:0]         vector_out,
  output logic [$clog2(N):0]              count_out,
  output logic                            error_out
);

  localparam int CW   = $clog2(MAX_CHAINS);
  localparam int CNTW = $clog2(N);
  localparam int OW   = CNTW + 1;
  localparam int VW   = N * DATA_WIDTH;

  logic [7:0]            config_byte_reg [MAX_CHAINS];
  logic [CW-1:0]         cfg_ptr_reg;
  logic [DATA_WIDTH-1:0] buffer_reg [N];

  logic [CNTW-1:0] count_reg, count_next;
  logic [CW-1:0]   cur_chain_reg, cur_chain_next;
  logic            error_reg, error_next;
  logic            valid_out_reg, valid_out_next;
  logic [VW-1:0]   vector_out_reg, vector_out_next;
  logic [OW-1:0]   count_out_reg, count_out_next;

  logic                  buf_we;
  logic [DATA_WIDTH-1:0] scalar_in;
  logic                  cfg_we;
  logic                  pack_mode;
  logic                  chain_switch;
  logic [CNTW-1:0]       base;
  logic [OW-1:0]         fill_cnt;
  logic                  pack_full;
  logic [VW-1:0]         pack_vec;

  assign scalar_in    = vector_in[DATA_WIDTH-1:0];
  assign cfg_we       = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));
  assign pack_mode    = (config_byte_reg[chainId_in] == 8'd1);
  // A scalar from a different chain abandons the partial buffer and restarts at slot 0.
  assign chain_switch = valid_in && pack_mode && (count_reg != '0) && (chainId_in != cur_chain_reg);
  assign base         = chain_switch ? '0 : count_reg;
  assign fill_cnt     = {1'b0, base} + OW'(1);
  assign pack_full    = (fill_cnt == OW'(N));

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack_lane
      localparam logic [OW-1:0] LANE = OW'(gi);
      assign pack_vec[gi*DATA_WIDTH +: DATA_WIDTH] =
        (LANE < {1'b0, base})  ? buffer_reg[gi] :
        (LANE == {1'b0, base}) ? scalar_in      : '0;
    end
  endgenerate

`ifdef VSPU_FLUSH_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_reg, idle_next;
  logic          timeout_hit;
  logic [VW-1:0] flush_vec;

  // Valid input in the expiry cycle wins, so the flush requires valid_in=0.
  assign timeout_hit = !valid_in && (count_reg != '0) && (idle_reg == IW'(TIMEOUT - 1));

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_flush_lane
      localparam logic [OW-1:0] LANE = OW'(gi);
      assign flush_vec[gi*DATA_WIDTH +: DATA_WIDTH] =
        (LANE < {1'b0, count_reg}) ? buffer_reg[gi] : '0;
    end
  endgenerate

  always_comb begin
    idle_next = '0;
    if (!valid_in && !timeout_hit && (count_reg != '0))
      idle_next = idle_reg + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) idle_reg <= '0;
    else       idle_reg <= idle_next;
  end
`endif

  always_comb begin
    count_next      = count_reg;
    cur_chain_next  = cur_chain_reg;
    error_next      = error_reg;
    valid_out_next  = 1'b0;
    vector_out_next = '0;
    count_out_next  = '0;
    buf_we          = 1'b0;
    if (valid_in) begin
      if (!pack_mode) begin
        valid_out_next  = 1'b1;
        vector_out_next = vector_in;
        count_out_next  = OW'(N);
        if (count_reg != '0) begin
          error_next = 1'b1;
          count_next = '0;
        end
      end else begin
        if (chain_switch) error_next = 1'b1;
        buf_we         = 1'b1;
        cur_chain_next = chainId_in;
        if (pack_full || eof_in) begin
          valid_out_next  = 1'b1;
          vector_out_next = pack_vec;
          count_out_next  = fill_cnt;
          count_next      = '0;
        end else begin
          count_next = fill_cnt[CNTW-1:0];
        end
      end
    end
`ifdef VSPU_FLUSH_TIMEOUT_EN
    else if (timeout_hit) begin
      valid_out_next  = 1'b1;
      vector_out_next = flush_vec;
      count_out_next  = {1'b0, count_reg};
      count_next      = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg      <= '0;
      cur_chain_reg  <= '0;
      error_reg      <= 1'b0;
      valid_out_reg  <= 1'b0;
      vector_out_reg <= '0;
      count_out_reg  <= '0;
      cfg_ptr_reg    <= '0;
    end else begin
      count_reg      <= count_next;
      cur_chain_reg  <= cur_chain_next;
      error_reg      <= error_next;
      valid_out_reg  <= valid_out_next;
      vector_out_reg <= vector_out_next;
      count_out_reg  <= count_out_next;
      if (tracing)
        cfg_ptr_reg <= '0;
      else if (cfg_we)
        cfg_ptr_reg <= (cfg_ptr_reg == CW'(MAX_CHAINS - 1)) ? '0 : cfg_ptr_reg + CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_CHAINS; gi++) begin : g_cfg
      always_ff @(posedge clk) begin
        if (reset)
          config_byte_reg[gi] <= 8'd0;
        else if (cfg_we && (cfg_ptr_reg == CW'(gi)))
          config_byte_reg[gi] <= configData;
      end
    end
  endgenerate

  // Buffer contents are masked by count on every read, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we) buffer_reg[base] <= scalar_in;
  end

  assign valid_out  = valid_out_reg;
  assign vector_out = vector_out_reg;
  assign count_out  = count_out_reg;
  assign error_out  = error_reg;

endmodule

// File: tb/tb_vector_scalar_pack_unit.sv
// Directed bench for vector_scalar_pack_unit (N=8, DATA_WIDTH=32, TIMEOUT=4).
module tb_vector_scalar_pack_unit;

  logic         clk;
  logic         reset;
  logic         valid_in;
  logic         eof_in;
  logic [1:0]   chainId_in;
  logic         tracing;
  logic [7:0]   configId;
  logic [7:0]   configData;
  logic [255:0] vector_in;
  logic         valid_out;
  logic [255:0] vector_out;
  logic [3:0]   count_out;
  logic         error_out;

  int n_cmp = 0;
  int n_bad = 0;

  vector_scalar_pack_unit #(
    .N(8), .DATA_WIDTH(32), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(0), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .eof_in(eof_in),
    .chainId_in(chainId_in), .tracing(tracing), .configId(configId),
    .configData(configData), .vector_in(vector_in), .valid_out(valid_out),
    .vector_out(vector_out), .count_out(count_out), .error_out(error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Lanes 0..n-1 hold start, start+1, ...; remaining lanes zero.
  function automatic logic [255:0] seqvec(input int start, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*32 +: 32] = 32'(start + i);
    return r;
  endfunction

  // Scalar in lane 0 with junk in upper lanes, which pack mode must ignore.
  function automatic logic [255:0] scal(input int v);
    logic [255:0] r;
    r = {{7{32'hDEADBEEF}}, 32'(v)};
    return r;
  endfunction

  task automatic step(input logic v, input logic eof, input logic [1:0] ch, input logic [255:0] vec);
    valid_in   = v;
    eof_in     = eof;
    chainId_in = ch;
    vector_in  = vec;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    eof_in   = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] b);
    configId   = 8'd0;
    configData = b;
    @(posedge clk);
    #1;
    configId = 8'hFF;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; eof_in = 1'b0; chainId_in = 2'd0;
    tracing = 1'b0; configId = 8'hFF; configData = 8'd0; vector_in = '0;
    idle_cycle();
    idle_cycle();
    check_val("rst_valid", valid_out, 0);
    check_val("rst_vec", vector_out, 0);
    check_val("rst_cnt", count_out, 0);
    check_val("rst_err", error_out, 0);
    reset = 1'b0;

    step(1, 0, 0, seqvec(1, 8));
    check_val("pt_valid", valid_out, 1);
    check_val("pt_vec", vector_out, seqvec(1, 8));
    check_val("pt_cnt", count_out, 8);
    check_val("pt_err", error_out, 0);

    // Chains 1 and 2 pack, chains 0 and 3 passthrough.
    cfg_write(8'd0);
    cfg_write(8'd1);
    cfg_write(8'd1);
    cfg_write(8'd0);

    for (int k = 0; k < 8; k++) begin
      step(1, 0, 1, scal(10 + k));
      if (k == 0) check_val("fill_vec_zero", vector_out, 0);
      if (k < 7) check_val($sformatf("fill_valid_%0d", k), valid_out, 0);
    end
    check_val("full_valid", valid_out, 1);
    check_val("full_vec", vector_out, seqvec(10, 8));
    check_val("full_cnt", count_out, 8);

    step(1, 0, 1, scal(5));
    step(1, 0, 1, scal(6));
    step(1, 1, 1, scal(7));
    check_val("eof_valid", valid_out, 1);
    check_val("eof_vec", vector_out, seqvec(5, 3));
    check_val("eof_cnt", count_out, 3);
    step(1, 1, 1, scal(9));
    check_val("b2b_vec", vector_out, seqvec(9, 1));
    check_val("b2b_cnt", count_out, 1);
    check_val("b2b_err", error_out, 0);

    step(1, 0, 1, scal(20));
    step(1, 0, 1, scal(21));
    step(1, 1, 2, scal(30));
    check_val("sw_err", error_out, 1);
    check_val("sw_vec", vector_out, seqvec(30, 1));
    check_val("sw_cnt", count_out, 1);

    step(1, 0, 1, scal(40));
    step(1, 0, 0, seqvec(200, 8));
    check_val("ptd_vec", vector_out, seqvec(200, 8));
    check_val("ptd_cnt", count_out, 8);
    step(1, 1, 1, scal(41));
    check_val("ptd_next_vec", vector_out, seqvec(41, 1));
    check_val("ptd_next_cnt", count_out, 1);

    // Writes are ignored while tracing; the pointer also rewinds to 0.
    tracing = 1'b1;
    cfg_write(8'd1);
    tracing = 1'b0;
    step(1, 1, 0, seqvec(60, 8));
    check_val("trc_cnt", count_out, 8);

    // Config write in the same cycle as an input affects only later inputs.
    configId = 8'd0;
    configData = 8'd1;
    step(1, 1, 0, seqvec(100, 8));
    configId = 8'hFF;
    check_val("cfgsame_cnt", count_out, 8);
    check_val("cfgsame_vec", vector_out, seqvec(100, 8));
    step(1, 1, 0, scal(50));
    check_val("cfgafter_vec", vector_out, seqvec(50, 1));
    check_val("cfgafter_cnt", count_out, 1);

`ifdef VSPU_FLUSH_TIMEOUT_EN
    step(1, 0, 1, scal(60));
    step(1, 0, 1, scal(61));
    for (int k = 0; k < 3; k++) begin
      idle_cycle();
      check_val($sformatf("to_wait_%0d", k), valid_out, 0);
    end
    idle_cycle();
    check_val("to_valid", valid_out, 1);
    check_val("to_vec", vector_out, seqvec(60, 2));
    check_val("to_cnt", count_out, 2);

    step(1, 0, 1, scal(62));
    step(1, 0, 1, scal(63));
    idle_cycle();
    idle_cycle();
    idle_cycle();
    step(1, 0, 1, scal(64));
    check_val("to_pre_valid", valid_out, 0);
    step(1, 1, 1, scal(65));
    check_val("to_pre_vec", vector_out, seqvec(62, 4));
    check_val("to_pre_cnt", count_out, 4);
`endif

    for (int k = 0; k < 5; k++) step(1, 0, 1, scal(70 + k));
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    check_val("mid_rst_valid", valid_out, 0);
    check_val("mid_rst_err", error_out, 0);
    idle_cycle();
    check_val("mid_rst_idle", valid_out, 0);
    step(1, 0, 1, seqvec(1, 8));
    check_val("mid_rst_mode_valid", valid_out, 1);
    check_val("mid_rst_mode_vec", vector_out, seqvec(1, 8));
    check_val("mid_rst_mode_cnt", count_out, 8);
    check_val("mid_rst_mode_err", error_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
